pipe_stage_reg: RTL

- Parametrised inter-stage pipeline register for the LoongArch core. Generalises the fixed MEM/WB latch.
- Configurable payload width and a valid/ready handshake in place of a single enable.
- Optional 2-entry skid mode, so in_ready is driven from a flop and does not depend combinationally on out_ready.
- Adds flush, a parametrised drop-PC filter, and a saturating stall counter.
- Instantiated between any two pipeline stages (IF/ID … MEM/WB).

---
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready
// handshake, optional two-entry skid buffer, flush, PC drop filter and a
// saturating stall counter.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   flush           invalidate every held and incoming beat
//   in_valid/ready  upstream handshake (in_ready is the stage's allowin)
//   in_data, in_pc  upstream payload and PC
//   out_valid/ready downstream handshake
//   out_data,out_pc held payload and PC (always registered)
//   stall_cnt       cycles spent with out_valid=1 and out_ready=0 (saturates)
module pipe_stage_reg #(
  parameter int          DW      = 38,
  parameter int          SKID    = 0,
  parameter int          DROP_EN = 1,
  parameter logic [31:0] DROP_PC = 32'h1bfffffc,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   pc;
  } beat_t;

  // Encoding chosen so bit 0 is the main-entry valid and bit 1 is the
  // skid-entry valid: both handshake outputs come straight off a flop.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic  accept, drain, drop, store;
  beat_t in_beat;

  assign in_beat = '{data: in_data, pc: in_pc};
  assign accept  = in_valid & in_ready;
  assign drain   = out_valid & out_ready;
  // A dropped beat completes its handshake but is never stored.
  assign drop    = accept & (DROP_EN != 0) & (in_pc == DROP_PC);
  assign store   = accept & ~drop;

  if (SKID == 0) begin : g_reg
    logic  vld_q;
    beat_t main_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        main_q <= '0;
      end else if (flush) begin
        vld_q  <= 1'b0;
      end else if (store) begin
        vld_q  <= 1'b1;
        main_q <= in_beat;
      end else if (drain) begin
        vld_q  <= 1'b0;
      end
    end

    assign in_ready  = ~vld_q | out_ready;
    assign out_valid = vld_q;
    assign out_data  = main_q.data;
    assign out_pc    = main_q.pc;
  end else begin : g_skid
    state_t state_q, state_d;
    beat_t  main_q, skid_q;
    logic   ld_main_in, ld_main_skid, ld_skid;

    always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state_q)
        EMPTY: if (store) begin
          state_d    = ONE;
          ld_main_in = 1'b1;
        end
        ONE: begin
          if (store && drain) begin
            ld_main_in = 1'b1;
          end else if (store) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drain) begin
          // in_ready is low here, so nothing can arrive alongside.
          state_d      = ONE;
          ld_main_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
      if (flush) begin
        state_d      = EMPTY;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (ld_main_in)        main_q <= in_beat;
        else if (ld_main_skid) main_q <= skid_q;
        if (ld_skid)           skid_q <= in_beat;
      end
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q.data;
    assign out_pc    = main_q.pc;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule
